data_memory_responder: RTL and testbench

//  Data-memory responder for the pipeline MEM stage. Consumes the per-instruction control produced by the
//  MEM-stage decode (write enable for STORE 4'b1100, address select for COPY INPUT 4'b1111).

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 22 ++
 rtl/data_memory_responder.sv | 149 ++++++++++++++
 tb/tb_data_memory_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data-memory responder and the MEM-stage decode.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } dmem_state_e;

  localparam logic [3:0] OP_STORE      = 4'b1100;
  localparam logic [3:0] OP_COPY_INPUT = 4'b1111;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read of the addressed word.
// WORD_W carries the extra parity bit when the top is built with DMEM_PARITY_EN.
module dmem_array #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= din;
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data-memory responder: request latch, latency counter and IDLE/ACCESS/RESPOND FSM.
// Build option DMEM_PARITY_EN adds an even-parity bit per word and reports read mismatches on rsp_err.
//
//   state   | meaning
//   IDLE    | no access in flight, ready for a request
//   ACCESS  | latched access counting down; array touched on the terminal count
//   RESPOND | rsp_valid pulse; may accept the next request back-to-back
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_addr_sel,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rdata,
  output logic              rsp_err,
  output logic              stall
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("data_memory_responder: LATENCY must be within 1..15");
  end

`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              mem_we;
  logic [WORD_W-1:0] mem_din;
  logic [WORD_W-1:0] mem_dout;

`ifdef DMEM_PARITY_EN
  assign mem_din = {^wdata_q, wdata_q};
`else
  assign mem_din = wdata_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_write_d = rsp_write_q;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    req_ready   = (state_q == IDLE) || (state_q == RESPOND);
    accept      = req_valid & req_ready;

    // The address path is chosen here, once, so later operand changes cannot leak in.
    if (accept) begin
      write_d = req_write;
      addr_d  = req_addr_sel ? input_addr : alu_addr;
      wdata_d = wdata;
      cnt_d   = CNT_W'(LATENCY - 1);
    end

    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d     = RESPOND;
          rsp_write_d = write_q;
          // Gated by resetn so a reset on the terminal edge never commits a store.
          mem_we      = write_q & resetn;
          if (write_q) begin
            rdata_d   = wdata_q;
            rsp_err_d = 1'b0;
          end else begin
            rdata_d   = mem_dout[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
            rsp_err_d = ^mem_dout;
`else
            rsp_err_d = 1'b0;
`endif
          end
        end
      end
      RESPOND: state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_write_q <= 1'b0;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_write_q <= rsp_write_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_array #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clock(clock),
    .we   (mem_we),
    .addr (addr_q),
    .din  (mem_din),
    .dout (mem_dout)
  );

  assign rsp_valid = (state_q == RESPOND);
  assign rsp_write = rsp_write_q;
  assign rdata     = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign stall     = req_valid & ~req_ready;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: table vectors, multi-cycle corner sequences,
// and randomized traffic against a word-array reference model.
`timescale 1ns/1ps
module tb_data_memory_responder;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_write, req_addr_sel;
  logic [AW-1:0] alu_addr, input_addr;
  logic [DW-1:0] wdata, rdata;
  logic          rsp_valid, rsp_write, rsp_err, stall;

  always #5 clock = ~clock;

  data_memory_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr_sel(req_addr_sel), .alu_addr(alu_addr), .input_addr(input_addr),
    .wdata(wdata), .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rdata(rdata), .rsp_err(rsp_err), .stall(stall)
  );

  typedef struct {
    logic          wr;
    logic          sel;
    logic [AW-1:0] aa;
    logic [AW-1:0] ia;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t          tbl[9];
  logic [DW-1:0] model [256];
  logic [AW-1:0] waddrs[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_write    = 1'($urandom_range(0, 1));
    req_addr_sel = 1'($urandom_range(0, 1));
    alu_addr     = AW'($urandom);
    input_addr   = AW'($urandom);
    wdata        = DW'($urandom);
  endtask

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_addr_sel = v.sel;
    alu_addr     = v.aa;
    input_addr   = v.ia;
    wdata        = v.wd;
  endtask

  // Issues one request (DUT must be ready) and returns in the RESPOND cycle.
  task automatic run_txn(input vec_t v, input logic exp_err, input string nm);
    int n;
    logic [AW-1:0] a;
    a = v.sel ? v.ia : v.aa;
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    drive(v);
    tick();
    idle_inputs();
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(LAT + 1));
    chk({nm, " rdata"}, 32'(rdata), 32'(v.exp_rd));
    chk({nm, " rsp_write"}, 32'(rsp_write), 32'(v.wr));
    chk({nm, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    if (v.wr) begin
      model[a] = v.wd;
      waddrs.push_back(a);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses;
    vec_t v;

    tbl[0] = '{1'b1, 1'b0, 8'h10, 8'h77, 16'h1234, 16'h1234};
    tbl[1] = '{1'b0, 1'b1, 8'h20, 8'h10, 16'h0000, 16'h1234};
    tbl[2] = '{1'b1, 1'b1, 8'h10, 8'h20, 16'h5A5A, 16'h5A5A};
    tbl[3] = '{1'b0, 1'b0, 8'h20, 8'h10, 16'hFFFF, 16'h5A5A};
    tbl[4] = '{1'b0, 1'b0, 8'h10, 8'h20, 16'h1111, 16'h1234};
    tbl[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 16'hFFFF, 16'hFFFF};
    tbl[6] = '{1'b1, 1'b1, 8'hFF, 8'h00, 16'h0000, 16'h0000};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 8'hFF, 16'h3333, 16'hFFFF};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 8'hFF, 16'h4444, 16'h0000};

    // Reset held with a request presented
    resetn = 1'b0;
    v = tbl[0];
    drive(v);
    tick();
    tick();
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_write", 32'(rsp_write), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset stall", 32'(stall), 32'd0);
    idle_inputs();
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid === 1'b1) pulses++;
    end
    chk("reset no accept", 32'(pulses), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i], 1'b0, $sformatf("tbl%0d", i));
      tick();
      chk($sformatf("tbl%0d pulse end", i), 32'(rsp_valid), 32'd0);
    end

    // Store then back-to-back read of the same word, second request stalled during ACCESS
    v = '{1'b1, 1'b0, 8'h05, 8'h99, 16'hBEEF, 16'hBEEF};
    drive(v);
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr_sel = 1'b1;
    input_addr = 8'h05; alu_addr = 8'h20; wdata = 16'h0;
    chk("b2b stall c1", 32'(stall), 32'd1);
    chk("b2b ready c1", 32'(req_ready), 32'd0);
    tick();
    chk("b2b stall c2", 32'(stall), 32'd1);
    tick();
    chk("b2b rsp1 valid", 32'(rsp_valid), 32'd1);
    chk("b2b rsp1 rdata", 32'(rdata), 32'hBEEF);
    chk("b2b rsp1 write", 32'(rsp_write), 32'd1);
    chk("b2b stall c3", 32'(stall), 32'd0);
    tick();
    idle_inputs();
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("b2b rsp spacing", 32'(n), 32'(LAT + 1));
    chk("b2b rsp2 rdata", 32'(rdata), 32'hBEEF);
    chk("b2b rsp2 write", 32'(rsp_write), 32'd0);
    model[8'h05] = 16'hBEEF;
    waddrs.push_back(8'h05);
    tick();

    // Reset during ACCESS abandons a store
    v = '{1'b1, 1'b0, 8'h05, 8'h00, 16'hAAAA, 16'hAAAA};
    drive(v);
    tick();
    idle_inputs();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1) pulses++;
      tick();
    end
    chk("abort no rsp", 32'(pulses), 32'd0);
    v = '{1'b0, 1'b0, 8'h05, 8'h33, 16'h0, 16'hBEEF};
    run_txn(v, 1'b0, "abort readback");
    tick();

`ifdef DMEM_PARITY_EN
    dut.u_array.mem_q[8'h10][DW] = ~dut.u_array.mem_q[8'h10][DW];
    v = '{1'b0, 1'b1, 8'h20, 8'h10, 16'h0, 16'h1234};
    run_txn(v, 1'b1, "parity err");
    tick();
    v = '{1'b1, 1'b0, 8'h10, 8'h00, 16'h1234, 16'h1234};
    run_txn(v, 1'b0, "parity repair");
    tick();
`else
    v = '{1'b0, 1'b1, 8'h20, 8'h10, 16'h0, 16'h1234};
    run_txn(v, 1'b0, "no parity err");
    tick();
`endif

    // Randomized traffic with idle gaps and back-to-back issue
    for (int k = 0; k < 200; k++) begin
      logic [AW-1:0] a;
      int gap;
      v.wr  = ($urandom_range(0, 2) == 0) || (waddrs.size() == 0);
      v.sel = 1'($urandom_range(0, 1));
      if (v.wr) a = AW'($urandom);
      else      a = waddrs[$urandom_range(0, waddrs.size() - 1)];
      v.aa = v.sel ? AW'($urandom) : a;
      v.ia = v.sel ? a : AW'($urandom);
      v.wd = DW'($urandom);
      v.exp_rd = v.wr ? v.wd : model[a];
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        if (g == 0) chk("rand pulse end", 32'(rsp_valid), 32'd0);
      end
      run_txn(v, 1'b0, $sformatf("rand%0d", k));
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
